// File: rtl/rr_arb_tree.sv
// rr_arb_tree: round-robin arbitration tree with priority pointer and lock-in.
// Define RR_ARB_TREE_ASSERT_EN to compile in simulation-only protocol checks.
module rr_arb_tree #(
    parameter int unsigned NumIn     = 2,
    parameter int unsigned DataWidth = 32,
    parameter bit          ExtPrio   = 1'b0,
    parameter bit          AxiVldRdy = 1'b0,
    parameter bit          LockIn    = 1'b0,
    parameter int unsigned IdxWidth  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic [IdxWidth-1:0]            rr_i,
    input  logic [NumIn-1:0]               req_i,
    output logic [NumIn-1:0]               gnt_o,
    input  logic [NumIn*DataWidth-1:0]     data_i,
    output logic                           req_o,
    input  logic                           gnt_i,
    output logic [DataWidth-1:0]           data_o,
    output logic [IdxWidth-1:0]            idx_o
);

    localparam int unsigned NumLeaf = 1 << IdxWidth;

    typedef logic [IdxWidth-1:0]  idx_t;
    typedef logic [DataWidth-1:0] data_t;

    logic [NumIn-1:0] req_q, req_d, req_eff;
    logic             lock_q, lock_d;
    idx_t             rr_q, rr_d, rr;

    logic [NumLeaf-1:0] leaf_req;
    data_t              leaf_dat [NumLeaf];

    logic [NumLeaf-1:0] nreq;
    idx_t               nidx [NumLeaf];
    data_t              ndat [NumLeaf];

    // While locked, arbitrate on the request vector frozen at the stall.
    assign req_eff = (LockIn && lock_q) ? req_q : req_i;
    assign rr      = ExtPrio ? rr_i : rr_q;

    for (genvar g = 0; g < NumLeaf; g++) begin : g_leaf
        if (g < NumIn) begin : g_real
            assign leaf_req[g] = req_eff[g];
            assign leaf_dat[g] = data_i[g*DataWidth +: DataWidth];
        end else begin : g_pad
            assign leaf_req[g] = 1'b0;
            assign leaf_dat[g] = '0;
        end
    end

    // Reduce leaves pairwise; level l nodes steer on pointer bit l.
    always_comb begin
        logic sel;
        sel = 1'b0;
        for (int i = 0; i < NumLeaf; i++) begin
            nreq[i] = leaf_req[i];
            nidx[i] = idx_t'(i);
            ndat[i] = leaf_dat[i];
        end
        for (int l = 0; l < IdxWidth; l++) begin
            for (int k = 0; k < (NumLeaf >> (l + 1)); k++) begin
                sel     = nreq[2*k+1] & (~nreq[2*k] | rr[l]);
                nreq[k] = nreq[2*k] | nreq[2*k+1];
                nidx[k] = sel ? nidx[2*k+1] : nidx[2*k];
                ndat[k] = sel ? ndat[2*k+1] : ndat[2*k];
            end
        end
    end

    assign req_o  = nreq[0];
    assign idx_o  = nidx[0];
    assign data_o = ndat[0];

    // Only the selected input sees the downstream ready.
    always_comb begin
        for (int i = 0; i < NumIn; i++) begin
            gnt_o[i] = gnt_i & (idx_o == idx_t'(i)) & (AxiVldRdy | req_i[i]);
        end
    end

    // Next-state: pointer advances on a handshake, lock follows a stall.
    always_comb begin
        lock_d = LockIn & req_o & ~gnt_i;
        req_d  = lock_d ? req_eff : '0;
        rr_d   = rr_q;
        if (req_o && gnt_i) begin
            rr_d = (rr_q == idx_t'(NumIn - 1)) ? '0 : rr_q + 1'b1;
        end
    end

    // Pointer and lock state; flush wins over any update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            req_q  <= '0;
        end else if (flush_i) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            req_q  <= '0;
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            req_q  <= req_d;
        end
    end

`ifdef RR_ARB_TREE_ASSERT_EN
    if (NumIn < 1) begin : g_num_chk
        $error("rr_arb_tree: NumIn must be at least 1");
    end

    idx_t  chk_idx_q;
    data_t chk_dat_q;

    // Remember which input and word were frozen by the stall.
    always_ff @(posedge clk_i) begin
        if (lock_d) begin
            chk_idx_q <= idx_o;
            chk_dat_q <= data_o;
        end
    end

    // Mid-cycle protocol checks on grant and locked input.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (!$onehot0(gnt_o)) begin
                $error("rr_arb_tree: gnt_o not one-hot");
            end
            if (LockIn && lock_q) begin
                if (!req_i[chk_idx_q]) begin
                    $error("rr_arb_tree: locked request dropped");
                end
                if (data_i[chk_idx_q*DataWidth +: DataWidth] != chk_dat_q) begin
                    $error("rr_arb_tree: locked data changed");
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_arb_tree.sv
// tb_rr_arb_tree: directed bench with a behavioural reference model.
// Three configurations share stimulus: locked RR, external prio, NumIn=3.
module tb_rr_arb_tree;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        gnt = 1'b0;
    logic [3:0]  req = 4'h0;
    logic [31:0] data = 32'h44332211;
    logic [1:0]  rr_ext = 2'd3;
    bit          chk_on = 1'b0;

    logic        req4, reqe, req3;
    logic [1:0]  idx4, idxe, idx3;
    logic [3:0]  gnt4, gnte;
    logic [2:0]  gnt3;
    logic [7:0]  d4, de, d3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_arb_tree #(.NumIn(4), .DataWidth(8), .ExtPrio(1'b0),
                  .AxiVldRdy(1'b0), .LockIn(1'b1)) u4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .rr_i(2'd0),
        .req_i(req), .gnt_o(gnt4), .data_i(data), .req_o(req4),
        .gnt_i(gnt), .data_o(d4), .idx_o(idx4));

    rr_arb_tree #(.NumIn(4), .DataWidth(8), .ExtPrio(1'b1),
                  .AxiVldRdy(1'b1), .LockIn(1'b0)) ue (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .rr_i(rr_ext),
        .req_i(req), .gnt_o(gnte), .data_i(data), .req_o(reqe),
        .gnt_i(gnt), .data_o(de), .idx_o(idxe));

    rr_arb_tree #(.NumIn(3), .DataWidth(8), .ExtPrio(1'b0),
                  .AxiVldRdy(1'b0), .LockIn(1'b0)) u3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .rr_i(2'd0),
        .req_i(req[2:0]), .gnt_o(gnt3), .data_i(data[23:0]),
        .req_o(req3), .gnt_i(gnt), .data_o(d3), .idx_o(idx3));

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model state per configuration k (0=u4, 1=ue, 2=u3).
    int         mp [3];
    bit         ml [3];
    logic [3:0] mq [3];

    function automatic int nof(input int k);
        return (k == 2) ? 3 : 4;
    endfunction

    // Winner of the padded binary tree; -1 when nobody requests.
    function automatic int win(input int n, input logic [3:0] r,
                               input logic [1:0] p);
        int c [4];
        int w;
        int lf, rt;
        w = (n > 2) ? 2 : 1;
        for (int i = 0; i < 4; i++) c[i] = (i < n && r[i]) ? i : -1;
        for (int l = 0; l < w; l++) begin
            for (int k = 0; k < ((1 << w) >> (l + 1)); k++) begin
                lf = c[2*k];
                rt = c[2*k+1];
                c[k] = (rt >= 0 && (lf < 0 || p[l])) ? rt : lf;
            end
        end
        return c[0];
    endfunction

    function automatic logic [3:0] meff(input int k);
        logic [3:0] m;
        m = (k == 2) ? 4'b0111 : 4'b1111;
        return ml[k] ? mq[k] : (req & m);
    endfunction

    function automatic int mwin(input int k);
        logic [1:0] p;
        p = (k == 1) ? rr_ext : 2'(mp[k]);
        return win(nof(k), meff(k), p);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            for (int k = 0; k < 3; k++) begin
                mp[k] <= 0;
                ml[k] <= 1'b0;
                mq[k] <= 4'h0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                int  w;
                bit  nl;
                w  = mwin(k);
                nl = (k == 0) && (w >= 0) && !gnt;
                if (w >= 0 && gnt) mp[k] <= (mp[k] == nof(k) - 1) ? 0 : mp[k] + 1;
                ml[k] <= nl;
                mq[k] <= nl ? meff(k) : 4'h0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                int         w, ei;
                logic       er, ar;
                logic [1:0] ai;
                logic [7:0] ed, ad;
                logic [3:0] eg, ag;
                w  = mwin(k);
                er = (w >= 0);
                ei = er ? w : 0;
                ed = data[ei*8 +: 8];
                eg = 4'h0;
                for (int i = 0; i < nof(k); i++)
                    eg[i] = gnt && (ei == i) && ((k == 1) || req[i]);
                case (k)
                    0: begin ar = req4; ai = idx4; ad = d4; ag = gnt4; end
                    1: begin ar = reqe; ai = idxe; ad = de; ag = gnte; end
                    default: begin ar = req3; ai = idx3; ad = d3; ag = {1'b0, gnt3}; end
                endcase
                chk($sformatf("model%0d_req_o", k), 32'(ar), 32'(er));
                chk($sformatf("model%0d_idx_o", k), 32'(ai), 32'(ei));
                chk($sformatf("model%0d_data_o", k), 32'(ad), 32'(ed));
                chk($sformatf("model%0d_gnt_o", k), 32'(ag), 32'(eg));
            end
        end
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    int e4 [5] = '{0, 1, 2, 3, 0};
    int e3 [5] = '{0, 1, 2, 0, 1};

    initial begin
        rst = 1'b1;
        req = 4'h0;
        gnt = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_on = 1'b1;
        @(negedge clk);
        chk("rst_req_o", 32'(req4), 32'd0);
        chk("rst_idx_o", 32'(idx4), 32'd0);
        chk("rst_gnt_o", 32'(gnt4), 32'd0);
        chk("rst_data_o", 32'(d4), 32'h11);
        chk("rst_data3_o", 32'(d3), 32'h11);

        nxt();
        rst = 1'b0;
        req = 4'hf;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rr4_idx_%0d", i), 32'(idx4), 32'(e4[i]));
            chk($sformatf("rr3_idx_%0d", i), 32'(idx3), 32'(e3[i]));
            chk($sformatf("ext_idx_%0d", i), 32'(idxe), 32'd3);
            nxt();
        end

        req = 4'b0110;
        gnt = 1'b0;
        @(negedge clk);
        chk("lock_sel", 32'(idx4), 32'd1);
        nxt();
        req = 4'b0111;
        @(negedge clk);
        chk("lock_keep", 32'(idx4), 32'd1);
        chk("lock_req_o", 32'(req4), 32'd1);
        chk("lock_gnt_o", 32'(gnt4), 32'd0);
        nxt();
        gnt = 1'b1;
        @(negedge clk);
        chk("lock_hs_idx", 32'(idx4), 32'd1);
        chk("lock_hs_gnt", 32'(gnt4), 32'b0010);
        nxt();
        req = 4'hf;
        gnt = 1'b0;
        @(negedge clk);
        chk("ptr_after_lock", 32'(idx4), 32'd2);

        nxt();
        flush = 1'b1;
        @(negedge clk);
        nxt();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idx", 32'(idx4), 32'd0);
        nxt();
        gnt = 1'b1;
        @(negedge clk);
        chk("flush_hs_gnt", 32'(gnt4), 32'b0001);

        nxt();
        req = 4'b0100;
        gnt = 1'b0;
        @(negedge clk);
        chk("lock2_sel", 32'(idx4), 32'd2);
        nxt();
        req = 4'b0101;
        @(negedge clk);
        chk("lock2_hold", 32'(idx4), 32'd2);
        nxt();
        gnt = 1'b1;
        @(negedge clk);
        chk("lock2_hs_gnt", 32'(gnt4), 32'b0100);

        nxt();
        req = 4'b1000;
        data[31:24] = 8'hA5;
        @(negedge clk);
        chk("single_idx", 32'(idx4), 32'd3);
        chk("single_data", 32'(d4), 32'hA5);
        chk("single_gnt", 32'(gnt4), 32'b1000);
        nxt();
        gnt = 1'b0;
        @(negedge clk);
        chk("single_stall_gnt", 32'(gnt4), 32'd0);
        chk("single_stall_req", 32'(req4), 32'd1);

        nxt();
        req = 4'hf;
        @(negedge clk);
        chk("stall_locked_idx", 32'(idx4), 32'd3);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_stall_idx", 32'(idx4), 32'd0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_idx", 32'(idx4), 32'd0);
        nxt();
        chk_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
